mtc_wrr_arbiter: RTL and testbench

Multi-grant weighted round-robin arbiter, successor to the multi-grant round-robin PPA arbiter. Each accepted request vector yields one grant vector with up to `max_gnt_i` set bits (hard cap `AMOUNT_M`). Each requester carries a credit counter loaded from a programmable weight, so its share of grants is proportional to that weight. It sits between a request-collection stage and grant consumers, with valid/ready handshakes on both sides and one registered output stage.

---
 rtl/mtc_wrr_pkg.sv | 24 ++
 rtl/mtc_wrr_select.sv | 40 ++++
 rtl/mtc_wrr_arbiter.sv | 114 +++++++++++
 tb/tb_mtc_wrr_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mtc_wrr_pkg.sv
// Shared types and helpers for the mtc_wrr weighted round-robin arbiter.
// Weighting is enabled by defining MTC_WRR_WEIGHT_EN (see mtc_wrr_arbiter).
package mtc_wrr_pkg;

    localparam int WIDTH_N_DEF  = 8;
    localparam int AMOUNT_M_DEF = 3;
    localparam int WEIGHT_W_DEF = 4;

    typedef logic [WEIGHT_W_DEF-1:0] credit_t;

    // Effective grant limit: 0 behaves as 1, anything above the cap saturates.
    function automatic int clamp_limit(input int max_gnt, input int amount);
        if (max_gnt < 1)
            return 1;
        if (max_gnt > amount)
            return amount;
        return max_gnt;
    endfunction

    function automatic int rot_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mtc_wrr_select.sv
// Combinational multi-grant selector: grants the first i_limit eligible lanes
// scanning from i_ptr with wrap-around, and reports the pointer after the last grant.
module mtc_wrr_select
    import mtc_wrr_pkg::*;
#(
    parameter int WIDTH_N = WIDTH_N_DEF,
    localparam int PTR_W  = $clog2(WIDTH_N)
) (
    input  logic [WIDTH_N-1:0] i_elig,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic [PTR_W:0]     i_limit,
    output logic [WIDTH_N-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_ptr_next
);

    int               w_cnt;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_last;

    always_comb begin
        o_gnt  = '0;
        w_cnt  = 0;
        w_idx  = i_ptr;
        w_last = i_ptr;
        for (int k = 0; k < WIDTH_N; k++) begin
            w_idx = PTR_W'(rot_idx(int'(i_ptr), k, WIDTH_N));
            if (i_elig[w_idx] && (w_cnt < int'(i_limit))) begin
                o_gnt[w_idx] = 1'b1;
                w_cnt        = w_cnt + 1;
                w_last       = w_idx;
            end
        end
        // With nothing granted the pointer holds so the next scan starts at the same lane.
        if (w_cnt == 0)
            o_ptr_next = i_ptr;
        else
            o_ptr_next = PTR_W'(rot_idx(int'(w_last), 1, WIDTH_N));
    end

endmodule

// File: rtl/mtc_wrr_arbiter.sv
// Multi-grant weighted round-robin arbiter with per-lane credits and one registered output stage.
// Define MTC_WRR_WEIGHT_EN for weighted credits; otherwise credits reload to 1 (plain round-robin).
module mtc_wrr_arbiter
    import mtc_wrr_pkg::*;
#(
    parameter int WIDTH_N  = WIDTH_N_DEF,
    parameter int AMOUNT_M = AMOUNT_M_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [WIDTH_N-1:0]              req_i,
    input  logic                            req_vld_i,
    output logic                            req_rdy_o,
    input  logic [WIDTH_N*WEIGHT_W-1:0]     weight_i,
    input  logic [$clog2(AMOUNT_M+1)-1:0]   max_gnt_i,
    output logic [WIDTH_N-1:0]              gnt_o,
    output logic                            gnt_vld_o,
    input  logic                            gnt_rdy_i
);

    localparam int PTR_W = $clog2(WIDTH_N);

    logic [WIDTH_N-1:0][WEIGHT_W-1:0] r_credit;
    logic [PTR_W-1:0]                 r_ptr;
    logic [WIDTH_N-1:0]               r_gnt;
    logic                             r_gnt_vld;

    logic [WIDTH_N-1:0][WEIGHT_W-1:0] w_load;
    logic [WIDTH_N-1:0][WEIGHT_W-1:0] w_credit_next;
    logic [WIDTH_N-1:0]               w_mask;
    logic [WIDTH_N-1:0]               w_cred_nz;
    logic [WIDTH_N-1:0]               w_load_nz;
    logic [WIDTH_N-1:0]               w_live;
    logic [WIDTH_N-1:0]               w_elig;
    logic [WIDTH_N-1:0]               w_gnt;
    logic [PTR_W-1:0]                 w_ptr_next;
    logic [PTR_W:0]                   w_limit;
    logic                             w_accept;
    logic                             w_reload;

`ifdef MTC_WRR_WEIGHT_EN
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_N; gi++) begin : g_load
            assign w_load[gi] = weight_i[gi*WEIGHT_W +: WEIGHT_W];
            assign w_mask[gi] = (weight_i[gi*WEIGHT_W +: WEIGHT_W] == '0);
        end
    endgenerate
`else
    logic w_unused_weight;
    assign w_unused_weight = ^weight_i;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH_N; gi++) begin : g_load
            assign w_load[gi] = WEIGHT_W'(1);
            assign w_mask[gi] = 1'b0;
        end
    endgenerate
`endif

    assign req_rdy_o = !r_gnt_vld || gnt_rdy_i;
    assign w_accept  = req_vld_i && req_rdy_o;
    assign w_limit   = (PTR_W+1)'(clamp_limit(int'(max_gnt_i), AMOUNT_M));

    generate
        for (gi = 0; gi < WIDTH_N; gi++) begin : g_lane
            assign w_cred_nz[gi] = (r_credit[gi] != '0);
            assign w_load_nz[gi] = (w_load[gi] != '0);
            // Reload and grant can share a cycle: decrement the freshly loaded value.
            assign w_credit_next[gi] =
                w_reload ? (w_load[gi] - WEIGHT_W'(w_gnt[gi])) :
                (w_gnt[gi] && w_cred_nz[gi]) ? (r_credit[gi] - WEIGHT_W'(1)) :
                r_credit[gi];
        end
    endgenerate

    // Masked lanes neither trigger a reload nor take part in one, so an
    // all-masked or empty request leaves credits untouched.
    assign w_live   = req_i & ~w_mask;
    assign w_reload = (|w_live) && !(|(w_live & w_cred_nz));
    assign w_elig   = w_live & (w_reload ? w_load_nz : w_cred_nz);

    mtc_wrr_select #(
        .WIDTH_N (WIDTH_N)
    ) u_select (
        .i_elig     (w_elig),
        .i_ptr      (r_ptr),
        .i_limit    (w_limit),
        .o_gnt      (w_gnt),
        .o_ptr_next (w_ptr_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credit  <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
        end else if (w_accept) begin
            r_credit  <= w_credit_next;
            r_ptr     <= w_ptr_next;
            r_gnt     <= w_gnt;
            r_gnt_vld <= 1'b1;
        end else if (gnt_rdy_i) begin
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_vld_o = r_gnt_vld;

endmodule

// File: tb/tb_mtc_wrr_arbiter.sv
// Directed-vector bench for mtc_wrr_arbiter; expectations follow the build
// selected by MTC_WRR_WEIGHT_EN.
module tb_mtc_wrr_arbiter;

    localparam int N = 8;
    localparam int M = 3;
    localparam int W = 4;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_i;
    logic           req_vld_i;
    logic           req_rdy_o;
    logic [N*W-1:0] weight_i;
    logic [1:0]     max_gnt_i;
    logic [N-1:0]   gnt_o;
    logic           gnt_vld_o;
    logic           gnt_rdy_i;

    int n_vec = 0;
    int n_err = 0;

    mtc_wrr_arbiter #(
        .WIDTH_N  (N),
        .AMOUNT_M (M),
        .WEIGHT_W (W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (req_i),
        .req_vld_i (req_vld_i),
        .req_rdy_o (req_rdy_o),
        .weight_i  (weight_i),
        .max_gnt_i (max_gnt_i),
        .gnt_o     (gnt_o),
        .gnt_vld_o (gnt_vld_o),
        .gnt_rdy_i (gnt_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Reset is applied away from the clock edge; outputs must settle immediately.
    task automatic do_reset();
        reset_n   = 1'b0;
        req_vld_i = 1'b0;
        req_i     = '0;
        gnt_rdy_i = 1'b1;
        #2;
        check_vec("rst.gnt_o", 32'(gnt_o), 32'h00);
        check_vec("rst.gnt_vld_o", 32'(gnt_vld_o), 32'h0);
        check_vec("rst.req_rdy_o", 32'(req_rdy_o), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_all_weights(input logic [W-1:0] w);
        for (int i = 0; i < N; i++)
            weight_i[i*W +: W] = w;
    endtask

    task automatic step_expect(input string tag, input logic [N-1:0] exp);
        @(posedge clk);
        #1;
        check_vec({tag, ".gnt"}, 32'(gnt_o), 32'(exp));
        check_vec({tag, ".vld"}, 32'(gnt_vld_o), 32'h1);
    endtask

    logic [N-1:0] exp_s1 [5];
    logic [N-1:0] exp_s2 [5];
    logic [N-1:0] exp_s5 [3];

    initial begin
        reset_n   = 1'b0;
        req_i     = '0;
        req_vld_i = 1'b0;
        weight_i  = '0;
        max_gnt_i = 2'd3;
        gnt_rdy_i = 1'b1;

        exp_s1 = '{8'h07, 8'h38, 8'hC0, 8'h07, 8'h38};
`ifdef MTC_WRR_WEIGHT_EN
        exp_s2 = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h02};
        exp_s5 = '{8'h00, 8'h00, 8'h07};
`else
        exp_s2 = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01};
        exp_s5 = '{8'h00, 8'h20, 8'hC1};
`endif

        // 1: plain rotation, three grants per vector
        do_reset();
        set_all_weights(4'd1);
        req_i     = 8'hFF;
        max_gnt_i = 2'd3;
        req_vld_i = 1'b1;
        for (int k = 0; k < 5; k++)
            step_expect($sformatf("s1.%0d", k), exp_s1[k]);

        // 2: lane0 weighted 3, single grant
        do_reset();
        set_all_weights(4'd1);
        weight_i[0 +: W] = 4'd3;
        req_i     = 8'h03;
        max_gnt_i = 2'd1;
        req_vld_i = 1'b1;
        for (int k = 0; k < 5; k++)
            step_expect($sformatf("s2.%0d", k), exp_s2[k]);

        // 3: backpressure freezes output and state
        do_reset();
        set_all_weights(4'd1);
        req_i     = 8'hFF;
        max_gnt_i = 2'd3;
        req_vld_i = 1'b1;
        step_expect("s3.first", 8'h07);
        gnt_rdy_i = 1'b0;
        #1;
        check_vec("s3.rdy_low", 32'(req_rdy_o), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step_expect($sformatf("s3.hold%0d", k), 8'h07);
            check_vec($sformatf("s3.rdy%0d", k), 32'(req_rdy_o), 32'h0);
        end
        gnt_rdy_i = 1'b1;
        #1;
        check_vec("s3.rdy_rel", 32'(req_rdy_o), 32'h1);
        step_expect("s3.next", 8'h38);

        // 4: limit clamping (0 acts as 1, top code acts as AMOUNT_M)
        do_reset();
        set_all_weights(4'd1);
        req_i     = 8'hFF;
        max_gnt_i = 2'd0;
        req_vld_i = 1'b1;
        step_expect("s4.lim0", 8'h01);
        max_gnt_i = 2'd3;
        step_expect("s4.lim3", 8'h0E);

        // 5: empty request, then a request only from a weight-0 lane
        do_reset();
        set_all_weights(4'd1);
        max_gnt_i = 2'd3;
        req_i     = 8'h00;
        req_vld_i = 1'b1;
        step_expect("s5.empty", exp_s5[0]);
        weight_i[5*W +: W] = 4'd0;
        req_i = 8'h20;
        step_expect("s5.masked", exp_s5[1]);
        req_i = 8'hFF;
        step_expect("s5.after", exp_s5[2]);

        // 6: idle drain, then asynchronous reset with a grant pending
        do_reset();
        set_all_weights(4'd1);
        req_i     = 8'hFF;
        max_gnt_i = 2'd3;
        req_vld_i = 1'b1;
        step_expect("s6.pre", 8'h07);
        req_vld_i = 1'b0;
        @(posedge clk);
        #1;
        check_vec("s6.drain", 32'(gnt_vld_o), 32'h0);
        req_vld_i = 1'b1;
        step_expect("s6.pend", 8'h38);
        reset_n = 1'b0;
        #1;
        check_vec("s6.rst.gnt", 32'(gnt_o), 32'h00);
        check_vec("s6.rst.vld", 32'(gnt_vld_o), 32'h0);
        check_vec("s6.rst.rdy", 32'(req_rdy_o), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step_expect("s6.post", 8'h07);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
